// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM-stage controller: FSM encoding, WB control
// bit positions and the alignment rule.
package mem_stage_pkg;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_BUSY = 1'b1;

    localparam int WB_REG_WRITE  = 1;
    localparam int WB_MEM_TO_REG = 0;

    function automatic logic word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/mem_stage_ctrl_timeout_cnt.sv
// Counts BUSY cycles without an acknowledge; o_hit flags the last cycle
// an access may wait before it is aborted.
module mem_timeout_cnt #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_en,
    output logic o_hit
);

    logic [CNT_W-1:0] r_cnt;

    // Wait-cycle counter, cleared while no access is outstanding
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_hit = (r_cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM stage: data-memory req/ack handshake with pipeline stall, branch
// resolution, MEM/WB register and sticky misalign/timeout error flags.
module mem_stage_ctrl
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        startin,
    input  logic [1:0]  MEM_wb,
    input  logic        MEM_branch,
    input  logic        MEM_mem_read,
    input  logic        MEM_mem_write,
    input  logic [31:0] MEM_branch_target,
    input  logic        MEM_zero,
    input  logic [31:0] MEM_alu_result,
    input  logic [31:0] MEM_forward_b_mux_out,
    input  logic [4:0]  MEM_reg_dst_mux_out,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        mem_stall,
    output logic        pc_src,
    output logic [31:0] pc_target,
    output logic [1:0]  WB_wb,
    output logic [31:0] WB_read_data,
    output logic [31:0] WB_alu_result,
    output logic [4:0]  WB_reg_dst,
    output logic        err_misalign,
    output logic        err_timeout
);

    logic r_state;
    logic w_idle;
    logic w_busy;
    logic w_access;
    logic w_aligned;
    logic w_start;
    logic w_misalign;
    logic w_ack;
    logic w_hit;
    logic w_abort;

    assign w_idle     = (r_state == ST_IDLE);
    assign w_busy     = (r_state == ST_BUSY);
    assign w_access   = MEM_mem_read | MEM_mem_write;
    assign w_aligned  = word_aligned(MEM_alu_result);
    assign w_start    = w_idle & w_access & w_aligned;
    assign w_misalign = w_idle & w_access & ~w_aligned;
    assign w_ack      = w_busy & dmem_ack;
    assign w_abort    = w_busy & ~dmem_ack & w_hit;

    // Stall is forced low while reset is held so the front end sees no freeze
    assign mem_stall = ~startin & (w_start | (w_busy & ~dmem_ack & ~w_hit));
    assign dmem_req  = w_busy;
    assign pc_src    = MEM_branch & MEM_zero;
    assign pc_target = MEM_branch_target;

    mem_timeout_cnt #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timeout_cnt (
        .clk     (clk),
        .rst     (startin),
        .i_clear (w_idle),
        .i_en    (w_busy & ~dmem_ack & ~w_hit),
        .o_hit   (w_hit)
    );

    // Access FSM; request fields are captured once and held for the access
    always_ff @(posedge clk or posedge startin) begin
        if (startin) begin
            r_state    <= ST_IDLE;
            dmem_addr  <= 32'h0000_0000;
            dmem_wdata <= 32'h0000_0000;
            dmem_we    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state    <= ST_BUSY;
                        dmem_addr  <= MEM_alu_result;
                        dmem_wdata <= MEM_forward_b_mux_out;
                        dmem_we    <= MEM_mem_write;
                    end else begin
                        r_state    <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (dmem_ack | w_hit) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_BUSY;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // MEM/WB register: bubble while stalled, aborted or misaligned accesses retire as bubbles
    always_ff @(posedge clk or posedge startin) begin
        if (startin) begin
            WB_wb         <= 2'b00;
            WB_read_data  <= 32'h0000_0000;
            WB_alu_result <= 32'h0000_0000;
            WB_reg_dst    <= 5'd0;
        end else if (mem_stall) begin
            WB_wb <= 2'b00;
        end else begin
            WB_wb         <= (w_abort | w_misalign) ? 2'b00 : MEM_wb;
            WB_read_data  <= (w_ack & ~dmem_we) ? dmem_rdata : 32'h0000_0000;
            WB_alu_result <= MEM_alu_result;
            WB_reg_dst    <= MEM_reg_dst_mux_out;
        end
    end

    // Sticky error flags
    always_ff @(posedge clk or posedge startin) begin
        if (startin) begin
            err_misalign <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            err_misalign <= err_misalign | w_misalign;
            err_timeout  <= err_timeout | w_abort;
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed test-plan steps followed by
// randomized instructions checked against a transaction-level model.
module tb_mem_stage_ctrl;
    import mem_stage_pkg::*;

    localparam int TMO = 4;

    logic        clk;
    logic        startin;
    logic [1:0]  MEM_wb;
    logic        MEM_branch;
    logic        MEM_mem_read;
    logic        MEM_mem_write;
    logic [31:0] MEM_branch_target;
    logic        MEM_zero;
    logic [31:0] MEM_alu_result;
    logic [31:0] MEM_forward_b_mux_out;
    logic [4:0]  MEM_reg_dst_mux_out;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic        mem_stall;
    logic        pc_src;
    logic [31:0] pc_target;
    logic [1:0]  WB_wb;
    logic [31:0] WB_read_data;
    logic [31:0] WB_alu_result;
    logic [4:0]  WB_reg_dst;
    logic        err_misalign;
    logic        err_timeout;

    int checks = 0;
    int errors = 0;
    bit exp_err_mis = 1'b0;
    bit exp_err_to  = 1'b0;

    mem_stage_ctrl #(.TIMEOUT(TMO), .CNT_W(3)) dut (
        .clk                   (clk),
        .startin               (startin),
        .MEM_wb                (MEM_wb),
        .MEM_branch            (MEM_branch),
        .MEM_mem_read          (MEM_mem_read),
        .MEM_mem_write         (MEM_mem_write),
        .MEM_branch_target     (MEM_branch_target),
        .MEM_zero              (MEM_zero),
        .MEM_alu_result        (MEM_alu_result),
        .MEM_forward_b_mux_out (MEM_forward_b_mux_out),
        .MEM_reg_dst_mux_out   (MEM_reg_dst_mux_out),
        .dmem_req              (dmem_req),
        .dmem_we               (dmem_we),
        .dmem_addr             (dmem_addr),
        .dmem_wdata            (dmem_wdata),
        .dmem_rdata            (dmem_rdata),
        .dmem_ack              (dmem_ack),
        .mem_stall             (mem_stall),
        .pc_src                (pc_src),
        .pc_target             (pc_target),
        .WB_wb                 (WB_wb),
        .WB_read_data          (WB_read_data),
        .WB_alu_result         (WB_alu_result),
        .WB_reg_dst            (WB_reg_dst),
        .err_misalign          (err_misalign),
        .err_timeout           (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_nop();
        MEM_wb = 2'b00; MEM_branch = 1'b0; MEM_zero = 1'b0;
        MEM_mem_read = 1'b0; MEM_mem_write = 1'b0;
        MEM_branch_target = 32'h0; MEM_alu_result = 32'h0;
        MEM_forward_b_mux_out = 32'h0; MEM_reg_dst_mux_out = 5'd0;
        dmem_ack = 1'b0; dmem_rdata = 32'h0;
    endtask

    task automatic check_all_clear(input string pfx);
        check({pfx, "_dmem_req"}, 32'(dmem_req), 32'd0);
        check({pfx, "_mem_stall"}, 32'(mem_stall), 32'd0);
        check({pfx, "_WB_wb"}, 32'(WB_wb), 32'd0);
        check({pfx, "_WB_read_data"}, WB_read_data, 32'd0);
        check({pfx, "_WB_alu_result"}, WB_alu_result, 32'd0);
        check({pfx, "_WB_reg_dst"}, 32'(WB_reg_dst), 32'd0);
        check({pfx, "_err_misalign"}, 32'(err_misalign), 32'd0);
        check({pfx, "_err_timeout"}, 32'(err_timeout), 32'd0);
    endtask

    // One instruction through MEM. Called just after a rising edge. lat is the
    // BUSY cycle in which the memory acks; lat > TMO means it never acks.
    task automatic run_instr(input logic [1:0] wb, input logic br, input logic zr,
                             input logic rd, input logic wr, input logic [31:0] alu,
                             input logic [31:0] sd, input logic [4:0] rdst,
                             input logic [31:0] tgt, input int lat, input logic [31:0] rdata);
        bit mem_ok, is_mem, timed_out;
        int n;
        MEM_wb = wb; MEM_branch = br; MEM_zero = zr;
        MEM_mem_read = rd; MEM_mem_write = wr;
        MEM_alu_result = alu; MEM_forward_b_mux_out = sd;
        MEM_reg_dst_mux_out = rdst; MEM_branch_target = tgt;
        is_mem    = rd | wr;
        mem_ok    = is_mem && (alu[1:0] == 2'b00);
        timed_out = mem_ok && (lat > TMO);
        n = !mem_ok ? 1 : (timed_out ? 1 + TMO : 1 + lat);
        for (int c = 0; c < n; c++) begin
            if (c == 0) dmem_ack = 1'($urandom_range(0, 1));
            else        dmem_ack = (c == lat);
            dmem_rdata = (c == lat) ? rdata : $urandom();
            #3;
            check("mem_stall", 32'(mem_stall), 32'(mem_ok && (c < n - 1)));
            check("dmem_req", 32'(dmem_req), 32'(mem_ok && (c > 0)));
            if (c == 0) begin
                check("pc_src", 32'(pc_src), 32'(br & zr));
                check("pc_target", pc_target, tgt);
            end
            if (mem_ok && c > 0) begin
                check("dmem_addr", dmem_addr, alu);
                check("dmem_we", 32'(dmem_we), 32'(wr));
                check("dmem_wdata", dmem_wdata, sd);
            end
            @(posedge clk);
            #1;
            if (c < n - 1) check("WB_wb_bubble", 32'(WB_wb), 32'd0);
        end
        dmem_ack = 1'b0;
        if (is_mem && !mem_ok) exp_err_mis = 1'b1;
        if (timed_out)         exp_err_to  = 1'b1;
        check("req_after", 32'(dmem_req), 32'd0);
        check("WB_wb", 32'(WB_wb), ((is_mem && !mem_ok) || timed_out) ? 32'd0 : 32'(wb));
        check("WB_read_data", WB_read_data,
              (rd && !wr && mem_ok && !timed_out) ? rdata : 32'd0);
        check("WB_alu_result", WB_alu_result, alu);
        check("WB_reg_dst", 32'(WB_reg_dst), 32'(rdst));
        check("err_misalign", 32'(err_misalign), 32'(exp_err_mis));
        check("err_timeout", 32'(err_timeout), 32'(exp_err_to));
    endtask

    initial begin
        logic [1:0] wb_ld;
        logic [31:0] a;
        int kind;
        wb_ld = 2'b00;
        wb_ld[WB_REG_WRITE]  = 1'b1;
        wb_ld[WB_MEM_TO_REG] = 1'b1;

        startin = 1'b1;
        drive_nop();
        repeat (2) @(posedge clk);
        #1;
        check_all_clear("reset");
        startin = 1'b0;
        @(posedge clk);
        #1;

        // Directed test-plan steps
        run_instr(wb_ld, 1'b0, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 5'd3, 32'h0, 3, 32'hDEADBEEF);
        run_instr(2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 32'h20, 32'h12345678, 5'd0, 32'h0, 1, 32'hCAFEF00D);
        run_instr(wb_ld, 1'b0, 1'b0, 1'b1, 1'b0, 32'h22, 32'h0, 5'd4, 32'h0, 1, 32'h1);
        run_instr(2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 32'h55, 32'h0, 5'd5, 32'h0, 1, 32'h0);
        run_instr(wb_ld, 1'b0, 1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 5'd6, 32'h0, TMO + 1, 32'h7);
        run_instr(2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 32'h400, 1, 32'h0);
        run_instr(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h4, 32'h0, 5'd0, 32'h400, 1, 32'h0);
        run_instr(2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 32'h80, 32'hA5A5A5A5, 5'd7, 32'h0, 2, 32'h99);

        // Reset in the middle of a BUSY access
        MEM_wb = wb_ld; MEM_mem_read = 1'b1; MEM_alu_result = 32'h100;
        MEM_reg_dst_mux_out = 5'd9; dmem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("busy_before_reset", 32'(dmem_req), 32'd1);
        startin = 1'b1;
        #1;
        check_all_clear("midreset");
        drive_nop();
        @(posedge clk);
        #1;
        startin = 1'b0;
        exp_err_mis = 1'b0;
        exp_err_to  = 1'b0;
        run_instr(wb_ld, 1'b0, 1'b0, 1'b1, 1'b0, 32'h104, 32'h0, 5'd10, 32'h0, 2, 32'h13579BDF);

        // Randomized instruction stream
        for (int i = 0; i < 80; i++) begin
            kind = $urandom_range(0, 4);
            a = $urandom();
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            run_instr(2'($urandom()), kind == 4, 1'($urandom()),
                      kind == 1 || kind == 3, kind == 2 || kind == 3,
                      a, $urandom(), 5'($urandom()), $urandom(),
                      $urandom_range(1, TMO + 1), $urandom());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs.
- Runs a req/ack handshake with a variable-latency data memory and stalls the front of the pipeline while an access is outstanding.
- Resolves branches (pc_src) and loads the MEM/WB register fields.
- Detects misaligned addresses and memory timeouts.

Parameters:
TIMEOUT, 16, max BUSY cycles without dmem_ack before the access is aborted (>=2)
CNT_W, 5, width of timeout counter (must hold TIMEOUT)

Ports:
clk  in  1  pipeline clock, rising edge
startin  in  1  reset, asynchronous, active-high
MEM_wb  in  2  WB control bits from EX/MEM
MEM_branch  in  1  branch instruction in MEM
MEM_mem_read  in  1  load
MEM_mem_write  in  1  store
MEM_branch_target  in  32  branch target address
MEM_zero  in  1  ALU zero flag
MEM_alu_result  in  32  effective address / ALU result
MEM_forward_b_mux_out  in  32  store data
MEM_reg_dst_mux_out  in  5  destination register
dmem_req  out  1  memory request, held until ack or abort
dmem_we  out  1  1 = write, 0 = read
dmem_addr  out  32  word-aligned byte address
dmem_wdata  out  32  store data
dmem_rdata  in  32  load data, valid with dmem_ack
dmem_ack  in  1  single-cycle completion strobe
mem_stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM this cycle
pc_src  out  1  take branch
pc_target  out  32  equals MEM_branch_target
WB_wb  out  2  MEM/WB control
WB_read_data  out  32  load data
WB_alu_result  out  32  ALU result passthrough
WB_reg_dst  out  5  destination register
err_misalign  out  1  sticky: misaligned access seen
err_timeout  out  1  sticky: access aborted on timeout

Behaviour:
- access = MEM_mem_read | MEM_mem_write. aligned = (MEM_alu_result[1:0] == 0).
- If read and write are both set, the write wins: treated as a store, WB_read_data = 0.
- Reset (async, any state, including mid-access): state = IDLE, counter = 0, every registered output = 0, both error flags cleared, dmem_req drops immediately.
- FSM states: IDLE, BUSY.
- IDLE:
  - access & aligned: mem_stall = 1. Next edge: latch dmem_addr, dmem_wdata and dmem_we, counter = 0, go to BUSY.
  - access & !aligned: no request, mem_stall = 0, err_misalign <= 1, instruction retires as a bubble (WB_wb <= 0).
  - dmem_ack while IDLE is ignored.
- BUSY:
  - dmem_req = 1 (Moore output). Address, data and we stay stable.
  - dmem_ack = 1: mem_stall = 0. Next edge: WB_read_data <= dmem_rdata (0 for a store), go to IDLE.
  - no ack and counter == TIMEOUT-1: mem_stall = 0, abort, err_timeout <= 1, WB_wb <= 0, go to IDLE.
  - otherwise: mem_stall = 1, counter += 1.
- mem_stall is combinational:
  - (IDLE & access & aligned) | (BUSY & !dmem_ack & !timeout_hit).
- Latency: a non-memory instruction takes 1 cycle in MEM. A memory instruction takes 1 + N cycles, where N is the number of BUSY cycles including the ack cycle; minimum 2.
- Back-to-back memory instructions: the next access enters IDLE the cycle after completion. There is no overlap.
- MEM/WB register update at every edge:
  - mem_stall = 1: WB_wb <= 0 (bubble). Other WB fields hold.
  - mem_stall = 0: WB_wb, WB_alu_result and WB_reg_dst load from MEM_*. WB_read_data loads as defined above (0 for non-load instructions).
- pc_src = MEM_branch & MEM_zero, combinational, independent of FSM state. Branches never access memory.
- Error flags are set-only until reset.

Decomposition:
- Shared package (mem_stage_pkg): state encoding (IDLE = 1'b0, BUSY = 1'b1) and WB control bit positions (RegWrite = bit 1, MemtoReg = bit 0).
- One sub-module is natural: mem_timeout_cnt (clear, enable, hit output at TIMEOUT-1).
- FSM and MEM/WB registers stay in the top.

Test Plan:
- Load, address 0x10, ack on 3rd BUSY cycle with rdata 0xDEADBEEF:
  - dmem_req high for 3 cycles, dmem_we = 0, dmem_addr = 0x10.
  - mem_stall high for 3 cycles total.
  - Next edge: WB_read_data = 0xDEADBEEF, WB_wb = MEM_wb.
- Store, address 0x20, data 0x12345678, ack in 1st BUSY cycle:
  - dmem_we = 1, dmem_wdata = 0x12345678.
  - mem_stall high exactly 1 cycle, WB_read_data = 0.
- Load, address 0x22 (misaligned):
  - No dmem_req, mem_stall stays 0.
  - err_misalign = 1 and stays 1, WB_wb = 0.
- Load with no ack, TIMEOUT = 4:
  - dmem_req high for 4 cycles, then low.
  - err_timeout = 1, WB_wb = 0, FSM returns to IDLE.
- MEM_branch = 1, MEM_zero = 1, target 0x400:
  - pc_src = 1 in the same cycle, pc_target = 0x400.
  - With MEM_zero = 0: pc_src = 0.
- Assert startin during BUSY:
  - dmem_req, mem_stall and all WB_* outputs = 0 immediately, error flags cleared.
  - After release, a new load completes normally.
